// File: rtl/keypad_pkg.sv
// Shared constants, FSM encoding and key helpers for the keypad entry path.
package keypad_pkg;

    localparam int DIGITS = 6;
    localparam int NIB_W  = 4;

    localparam logic [3:0] KEY_BKSP = 4'd10;
    localparam logic [3:0] KEY_CLR  = 4'd11;
    localparam logic [3:0] KEY_ENT  = 4'd15;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    function automatic logic one_hot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    function automatic logic [3:0] key_idx(input logic [15:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

endpackage

// File: rtl/keypad_entry_ctrl_if.sv
// Keypad input and display/commit output bundle of the entry controller.
interface keypad_entry_ctrl_if;
    import keypad_pkg::*;

    logic [15:0]      key_deb;
    logic [NIB_W-1:0] disp_data;
    logic             disp_blank;
    logic [5:0]       seg_sel;
    logic [2:0]       entry_cnt;
    logic [23:0]      value_out;
    logic             value_valid;
    logic             entry_err;

    modport master (
        output key_deb,
        input  disp_data, disp_blank, seg_sel,
        input  entry_cnt, value_out,
        input  value_valid, entry_err
    );

    modport slave (
        input  key_deb,
        output disp_data, disp_blank, seg_sel,
        output entry_cnt, value_out,
        output value_valid, entry_err
    );

endinterface

// File: rtl/keypad_entry_ctrl_disp_scan.sv
// Digit refresh: divider, position rotation and per-position nibble/blank.
module disp_scan #(
    parameter int CLK_HZ  = 50000000,
    parameter int SCAN_HZ = 1000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [23:0] buffer,
    input  logic [2:0]  entry_cnt,
    output logic [5:0]  seg_sel,
    output logic [3:0]  disp_data,
    output logic        disp_blank
);
    import keypad_pkg::*;

    localparam int TC = CLK_HZ / SCAN_HZ - 1;
    localparam int DW = (TC > 0) ? $clog2(TC + 1) : 1;

    logic [DW-1:0] div;
    logic [2:0]    idx;
    logic [2:0]    nxt_idx;
    logic          tc_hit;

    always_comb begin
        tc_hit  = (div == DW'(TC));
        nxt_idx = idx;
        if (tc_hit)
            nxt_idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    end

    // Outputs follow nxt_idx so select, data and blank move together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div        <= '0;
            idx        <= '0;
            seg_sel    <= 6'b111110;
            disp_data  <= '0;
            disp_blank <= 1'b0;
        end else begin
            div        <= tc_hit ? '0 : div + DW'(1);
            idx        <= nxt_idx;
            seg_sel    <= ~(6'b000001 << nxt_idx);
            disp_data  <= buffer[{nxt_idx, 2'b00} +: NIB_W];
            disp_blank <= (nxt_idx >= entry_cnt) && (nxt_idx != 3'd0);
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Key event FSM and 6-digit BCD entry buffer driving the scanned display.
module keypad_entry_ctrl #(
    parameter int CLK_HZ  = 50000000,
    parameter int SCAN_HZ = 1000,
    parameter int DIGITS  = 6
) (
    input  logic               clk,
    input  logic               rstn,
    keypad_entry_ctrl_if.slave bus
);
    import keypad_pkg::*;

    localparam logic [2:0] FULL = 3'(DIGITS);

    logic [0:0]  state;
    logic [23:0] buffer;
    logic [2:0]  cnt;
    logic [23:0] value;
    logic        vld;
    logic        err;
    logic        act;
    logic [3:0]  k;

    always_comb begin
        act = (state == IDLE) && one_hot(bus.key_deb);
        k   = key_idx(bus.key_deb);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            buffer <= '0;
            cnt    <= '0;
            value  <= '0;
            vld    <= 1'b0;
            err    <= 1'b0;
        end else begin
            vld <= 1'b0;
            err <= 1'b0;
            unique case (state)
                IDLE: if (bus.key_deb != 16'd0) state <= HELD;
                HELD: if (bus.key_deb == 16'd0) state <= IDLE;
            endcase
            if (act) begin
                unique case (1'b1)
                    (k <= 4'd9): begin
                        if (cnt < FULL) begin
                            buffer <= {buffer[19:0], k};
                            cnt    <= cnt + 3'd1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    (k == KEY_BKSP): begin
                        if (cnt != 3'd0) begin
                            buffer <= {4'd0, buffer[23:4]};
                            cnt    <= cnt - 3'd1;
                        end
                    end
                    (k == KEY_CLR): begin
                        buffer <= '0;
                        cnt    <= '0;
                    end
                    (k == KEY_ENT): begin
                        value  <= buffer;
                        vld    <= 1'b1;
                        buffer <= '0;
                        cnt    <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.entry_cnt   = cnt;
    assign bus.value_out   = value;
    assign bus.value_valid = vld;
    assign bus.entry_err   = err;

    disp_scan #(
        .CLK_HZ  (CLK_HZ),
        .SCAN_HZ (SCAN_HZ)
    ) u_scan (
        .clk        (clk),
        .rstn       (rstn),
        .buffer     (buffer),
        .entry_cnt  (cnt),
        .seg_sel    (bus.seg_sel),
        .disp_data  (bus.disp_data),
        .disp_blank (bus.disp_blank)
    );

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Randomized scoreboard bench for keypad_entry_ctrl against a digit-list model.
module tb_keypad_entry_ctrl;

    typedef struct {
        bit          is_err;
        logic [23:0] val;
    } ev_t;

    logic clk;
    logic rstn;
    keypad_entry_ctrl_if bus ();

    keypad_entry_ctrl #(
        .CLK_HZ  (16),
        .SCAN_HZ (4),
        .DIGITS  (6)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int          n_cmp;
    int          n_fail;
    int          digs[$];
    logic [23:0] last_val;
    ev_t         exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] model_val();
        int unsigned v;
        v = 0;
        foreach (digs[i]) v = v * 16 + digs[i];
        return 24'(v);
    endfunction

    function automatic logic [3:0] exp_nib(input int p);
        if (p < digs.size()) return 4'(digs[digs.size() - 1 - p]);
        return 4'd0;
    endfunction

    task automatic apply_key(input int k);
        if (k <= 9) begin
            if (digs.size() < 6) digs.push_back(k);
            else exp_q.push_back('{is_err: 1'b1, val: 24'd0});
        end else if (k == 10) begin
            if (digs.size() > 0) void'(digs.pop_back());
        end else if (k == 11) begin
            digs.delete();
        end else if (k == 15) begin
            last_val = model_val();
            exp_q.push_back('{is_err: 1'b0, val: last_val});
            digs.delete();
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int k, input int hold);
        bus.key_deb = 16'(1) << k;
        apply_key(k);
        step(hold);
        bus.key_deb = 16'd0;
        step(2);
    endtask

    task automatic chord(input logic [15:0] v, input int hold);
        bus.key_deb = v;
        step(hold);
        bus.key_deb = 16'd0;
        step(2);
    endtask

    task automatic check_state(input string tag);
        int idx;
        step(2);
        chk({tag, " entry_cnt"}, 32'(bus.entry_cnt), 32'(digs.size()));
        chk({tag, " value_out"}, 32'(bus.value_out), 32'(last_val));
        repeat (24) begin
            @(negedge clk);
            idx = 0;
            for (int i = 0; i < 6; i++)
                if (!bus.seg_sel[i]) idx = i;
            chk({tag, " seg_sel onehot"}, 32'($countones(~bus.seg_sel)), 32'd1);
            chk({tag, " disp_data"}, 32'(bus.disp_data), 32'(exp_nib(idx)));
            chk({tag, " disp_blank"}, 32'(bus.disp_blank),
                32'((idx >= digs.size()) && (idx != 0)));
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " seg_sel"}, 32'(bus.seg_sel), 32'h3E);
        chk({tag, " entry_cnt"}, 32'(bus.entry_cnt), 32'd0);
        chk({tag, " value_out"}, 32'(bus.value_out), 32'd0);
        chk({tag, " disp_blank"}, 32'(bus.disp_blank), 32'd0);
        chk({tag, " disp_data"}, 32'(bus.disp_data), 32'd0);
        chk({tag, " value_valid"}, 32'(bus.value_valid), 32'd0);
        chk({tag, " entry_err"}, 32'(bus.entry_err), 32'd0);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rstn && (bus.value_valid || bus.entry_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected event vld/err",
                    {30'd0, bus.value_valid, bus.entry_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event is_err", 32'(bus.entry_err), 32'(e.is_err));
                chk("event vld", 32'(bus.value_valid), 32'(!e.is_err));
                if (!e.is_err)
                    chk("event value_out", 32'(bus.value_out), 32'(e.val));
            end
        end
    end

    initial begin
        int a;
        int b;
        int op;
        n_cmp    = 0;
        n_fail   = 0;
        last_val = '0;
        rstn     = 1'b0;
        bus.key_deb = 16'd0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            chk("scan seg_sel", 32'(bus.seg_sel),
                32'(6'(~(6'd1 << ((c / 4) % 6)))));
        end
        #1;
        check_state("empty");

        press(1, 1); press(2, 3); press(3, 2);
        check_state("entry 123");
        press(15, 2);
        check_state("after enter");

        for (int i = 0; i < 7; i++) press(7, 2);
        check_state("full 777777");
        press(15, 1);
        press(15, 1);
        check_state("enter twice");

        press(4, 1); press(5, 1); press(6, 1); press(10, 2);
        check_state("bksp 45");
        press(11, 2);
        check_state("clear");
        press(10, 2);
        check_state("bksp empty");

        bus.key_deb = 16'h0003;
        step(3);
        bus.key_deb = 16'h0008;
        step(100);
        bus.key_deb = 16'h0000;
        step(2);
        check_state("chord hold");
        press(3, 2);
        check_state("after chord");

        press(8, 1); press(9, 1);
        @(posedge clk);
        #1 bus.key_deb = 16'h0020;
        #2 rstn = 1'b0;
        #1 check_reset_outputs("async reset");
        digs.delete();
        exp_q.delete();
        last_val = '0;
        #2 rstn = 1'b1;
        apply_key(5);
        step(4);
        bus.key_deb = 16'd0;
        step(2);
        check_state("post reset");

        for (int n = 0; n < 200; n++) begin
            op = $urandom_range(0, 9);
            if (op <= 7) begin
                press($urandom_range(0, 15), $urandom_range(1, 4));
            end else if (op == 8) begin
                a = $urandom_range(0, 15);
                b = (a + 1 + $urandom_range(0, 14)) % 16;
                chord((16'(1) << a) | (16'(1) << b), $urandom_range(1, 5));
            end else begin
                press($urandom_range(0, 9), $urandom_range(10, 40));
            end
            if ((n % 10) == 9) check_state("random");
        end

        step(4);
        chk("pending events", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
Controller between the keypad front end (keyboard_scan → key_filter) and the 6-digit seven-segment display.
- Turns debounced one-hot key levels into single key events.
- Runs a 6-digit BCD entry buffer with backspace, clear and enter.
- Time-multiplexes the buffer onto seg_sel and a 4-bit digit bus that drives the existing seg_led_decoder.
- Replaces the fixed single-digit display path.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
SCAN_HZ, 1000, per-digit refresh rate; divider terminal count = CLK_HZ/SCAN_HZ - 1
DIGITS, 6, number of display digits; fixed at 6, other values unsupported

Ports:
clk  in  1  system clock (50 MHz on board)
rstn  in  1  asynchronous active-low reset
key_deb  in  16  debounced key levels, bit k high = key k held
disp_data  out  4  BCD digit for the currently selected position, to seg_led_decoder
disp_blank  out  1  high = current position is blanked (top level forces seg_led to all-off)
seg_sel  out  6  active-low digit select; bit 0 = rightmost digit
entry_cnt  out  3  number of digits entered, 0..6
value_out  out  24  committed BCD value, nibble 0 = rightmost digit
value_valid  out  1  one-cycle pulse when value_out is updated
entry_err  out  1  one-cycle pulse when a digit is rejected because the buffer is full

Behaviour:
Reset: async assert on rstn low, synchronous release.
- seg_sel = 6'b111110, scan index = 0, divider = 0.
- Buffer = 0, entry_cnt = 0, value_out = 0.
- value_valid = 0, entry_err = 0, disp_data = 0, disp_blank = 0.

Key mapping:
- 0-9: digit of that value.
- 10: backspace.
- 11: clear.
- 15: enter.
- 12, 13, 14: ignored, but they still occupy the press/release cycle.

Event FSM, two states:
- IDLE: when key_deb has exactly one bit set, perform that key's action this cycle and go to HELD. Zero bits set: stay. Two or more bits set: go to HELD with no action.
- HELD: stay until key_deb == 0, then return to IDLE. So one press gives exactly one action, and a chord gives none.
- All actions register on the clock edge after the cycle of detection. Latency from key_deb change to updated buffer/entry_cnt outputs is 1 cycle.

Digit action:
- If entry_cnt < 6: shift buffer left one nibble, insert the digit at nibble 0, entry_cnt + 1.
- If entry_cnt == 6: buffer unchanged, entry_err pulses for 1 cycle.

Backspace:
- If entry_cnt > 0: shift buffer right one nibble, nibble 5 = 0, entry_cnt - 1.
- If entry_cnt == 0: no-op, no error.

Clear: buffer = 0, entry_cnt = 0.

Enter:
- value_out = buffer, value_valid pulses for 1 cycle, then buffer = 0 and entry_cnt = 0 on the same edge.
- Enter with entry_cnt == 0 commits 0 and still pulses value_valid.

Scan:
- Divider counts 0..CLK_HZ/SCAN_HZ-1. On terminal count: scan index advances 0→1→…→5→0 and the divider wraps to 0.
- seg_sel = ~(1 << index), so exactly one bit is low at all times.
- disp_data = buffer nibble[index].
- disp_blank = 1 when index >= entry_cnt and index != 0, so an empty buffer shows a single '0'.
- seg_sel, disp_data and disp_blank are registered and change on the same edge. A buffer update is visible on the next edge at the current position.

Other conditions:
- Reset mid-press: FSM returns to IDLE. A key still held after release of rstn is treated as a new press.
- Scan runs independently of the FSM; a buffer change never stalls or resets the scan.

Decomposition:
- Shared package keypad_pkg: KEY_BKSP=10, KEY_CLR=11, KEY_ENT=15, DIGITS=6, the FSM state encoding (IDLE, HELD), and the BCD nibble width of 4.
- Sub-module disp_scan: divider, index counter, seg_sel rotation, buffer nibble mux and blank logic. Inputs are clk, rstn, 24-bit buffer and entry_cnt.
- keypad_entry_ctrl contains the event FSM and the buffer, and instantiates disp_scan.

Test Plan:
All scenarios use CLK_HZ=16, SCAN_HZ=4, giving 4 cycles per digit.
- Reset: rstn low → seg_sel=111110, entry_cnt=0, value_out=0, disp_blank=0, disp_data=0. After release, seg_sel steps 111101, 111011, … every 4 cycles and wraps to 111110 after 24 cycles.
- Entry and enter: press/release 1, 2, 3, then 15 → buffer 0x000123, entry_cnt 3, one value_valid pulse with value_out=0x000123. Afterwards entry_cnt=0, and positions 1-5 are blanked while position 0 shows 0.
- Full buffer: press 7 seven times → buffer 0x777777, entry_cnt 6, exactly one entry_err pulse, on the 7th press.
- Edit keys: enter 4, 5, 6, press 10 → buffer 0x000045, entry_cnt 2. Press 11 → 0, entry_cnt 0. Backspace at entry_cnt 0 → no change, no err.
- Chord and hold: key_deb=0x0003 → no action. Then hold 0x0008 for 100 cycles without passing through 0 → still no action. Release to 0, press 0x0008 → exactly one insertion of 3.
- Async reset mid-entry: after 2 digits, pulse rstn low between clock edges → outputs return to reset values immediately. key_deb held at 0x0020 across reset → digit 5 inserted once after release.
